// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic unit: opcodes, FSM states and flag layout.
// Flags are packed MSB-first as {c, v, z, n}.
package arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_CMP = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } flags_t;

    function automatic flags_t make_flags(input logic c, input logic v,
                                          input logic z, input logic n);
        flags_t f;
        f.c = c;
        f.v = v;
        f.z = z;
        f.n = n;
        return f;
    endfunction

endpackage

// File: rtl/addsub_core.sv
// WIDTH-bit ripple adder/subtractor; sub inverts b, the caller supplies the carry-in.
// Also exposes the carry into the MSB so the caller can derive signed overflow.
module addsub_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   carry;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_binv
            assign bx[gi] = b[gi] ^ sub;
        end
    endgenerate

    // Chain kept in one process so the carry vector is evaluated in order.
    always_comb begin
        sum      = '0;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]       = a[i] ^ bx[i] ^ carry[i];
            carry[i + 1] = (a[i] & bx[i]) | (carry[i] & (a[i] ^ bx[i]));
        end
    end

    assign cout = carry[WIDTH];
    assign cmsb = carry[WIDTH-1];

endmodule

// File: rtl/arith_unit.sv
// Valid/ready arithmetic unit: single-cycle ADD/SUB/CMP, iterative shift-and-add MUL.
// One addsub_core is shared between the ALU path (IDLE) and the multiplier accumulate (MUL).
module arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n,
    output logic             busy
);

    localparam int CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam bit HAS_MUL = (MUL_EN != 0);

    state_e           state_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_hi_reg;
    flags_t           flags_reg;

    op_e  op_sel;
    logic accept;
    logic in_mul;
    logic is_sub;
    logic is_mul_op;
    logic mul_start;

    assign op_sel    = op_e'(op);
    assign in_mul    = (state_reg == ST_MUL);
    assign accept    = in_valid && in_ready;
    assign is_sub    = (op_sel == OP_SUB) || (op_sel == OP_CMP);
    assign is_mul_op = HAS_MUL && (op_sel == OP_MUL);
    assign mul_start = accept && is_mul_op;

    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic             core_cin;
    logic             core_sub;
    logic [WIDTH-1:0] core_sum;
    logic             core_cout;
    logic             core_cmsb;

    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic             mul_last;

    // While multiplying, the core adds the multiplicand into the high accumulator.
    assign core_a   = in_mul ? acc_hi : a;
    assign core_b   = in_mul ? mcand  : b;
    assign core_sub = !in_mul && is_sub;
    assign core_cin = in_mul ? 1'b0 : (is_sub ? 1'b1 : carry_in);

    addsub_core #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a    (core_a),
        .b    (core_b),
        .cin  (core_cin),
        .sub  (core_sub),
        .sum  (core_sum),
        .cout (core_cout),
        .cmsb (core_cmsb)
    );

    flags_t alu_flags;
    flags_t mul_flags;

    assign alu_flags = make_flags(core_cout, core_cout ^ core_cmsb,
                                  core_sum == '0, core_sum[WIDTH-1]);
    assign mul_flags = make_flags(mul_hi != '0, 1'b0,
                                  (mul_hi == '0) && (mul_lo == '0), mul_hi[WIDTH-1]);

    generate
        if (MUL_EN != 0) begin : g_mul
            logic [CNT_W-1:0] cnt_reg;
            logic [WIDTH-1:0] acc_hi_reg;
            logic [WIDTH-1:0] acc_lo_reg;
            logic [WIDTH-1:0] mcand_reg;

            // {acc_hi, acc_lo} shifts right each step; acc_lo starts as the multiplier.
            assign mul_hi = acc_lo_reg[0] ? {core_cout, core_sum[WIDTH-1:1]}
                                          : {1'b0, acc_hi_reg[WIDTH-1:1]};
            assign mul_lo = {(acc_lo_reg[0] ? core_sum[0] : acc_hi_reg[0]),
                             acc_lo_reg[WIDTH-1:1]};

            assign mul_last = in_mul && (cnt_reg == '0);
            assign acc_hi   = acc_hi_reg;
            assign mcand    = mcand_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg    <= '0;
                    acc_hi_reg <= '0;
                    acc_lo_reg <= '0;
                    mcand_reg  <= '0;
                end else if (mul_start) begin
                    cnt_reg    <= CNT_W'(WIDTH - 1);
                    acc_hi_reg <= '0;
                    acc_lo_reg <= b;
                    mcand_reg  <= a;
                end else if (in_mul) begin
                    acc_hi_reg <= mul_hi;
                    acc_lo_reg <= mul_lo;
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
            end
        end else begin : g_nomul
            assign mul_hi   = '0;
            assign mul_lo   = '0;
            assign mul_last = 1'b0;
            assign acc_hi   = '0;
            assign mcand    = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            result_hi_reg <= '0;
            flags_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (mul_start) begin
                            state_reg     <= ST_MUL;
                            out_valid_reg <= 1'b0;
                        end else begin
                            out_valid_reg <= 1'b1;
                            flags_reg     <= alu_flags;
                            // CMP only refreshes the flags.
                            if (op_sel != OP_CMP) begin
                                result_reg    <= core_sum;
                                result_hi_reg <= '0;
                            end
                        end
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (mul_last) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b1;
                        result_reg    <= mul_lo;
                        result_hi_reg <= mul_hi;
                        flags_reg     <= mul_flags;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
    assign busy      = in_mul;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign result_hi = result_hi_reg;
    assign flag_c    = flags_reg.c;
    assign flag_v    = flags_reg.v;
    assign flag_z    = flags_reg.z;
    assign flag_n    = flags_reg.n;

endmodule

// File: tb/tb_arith_unit.sv
// Bench for arith_unit (WIDTH=8): vector table through a scoreboard plus
// hand-written latency, backpressure, reset-abort and back-to-back sequences.
module tb_arith_unit;

    localparam int W = 8;
    localparam logic [1:0] OPC_ADD = 2'b00;
    localparam logic [1:0] OPC_SUB = 2'b01;
    localparam logic [1:0] OPC_MUL = 2'b10;
    localparam logic [1:0] OPC_CMP = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         flag_c, flag_v, flag_z, flag_n;
    logic         busy;

    always #5 clk = ~clk;

    arith_unit #(
        .WIDTH  (W),
        .MUL_EN (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .busy      (busy)
    );

    typedef struct {
        logic [7:0] res;
        logic [7:0] hi;
        logic [3:0] f;    // {c, v, z, n}
    } exp_t;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] res;
        logic [7:0] hi;
        logic [3:0] f;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[13];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic exp_t model_add(input logic [7:0] x, input logic [7:0] y, input logic ci);
        logic [8:0] s;
        exp_t e;
        s = {1'b0, x} + {1'b0, y} + {8'b0, ci};
        e.res = s[7:0];
        e.hi  = 8'h00;
        e.f   = {s[8], (x[7] == y[7]) && (s[7] != x[7]), s[7:0] == 8'h00, s[7]};
        return e;
    endfunction

    // Scoreboard side: a transfer happens on the next posedge when both are high.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got result=%h with nothing expected", result);
            end else begin
                e = sb.pop_front();
                n_txn++;
                $display("txn %0d: result=%h hi=%h cvzn=%b (expect %h %h %b)",
                         n_txn, result, result_hi, {flag_c, flag_v, flag_z, flag_n},
                         e.res, e.hi, e.f);
                check("result", result, e.res);
                check("result_hi", result_hi, e.hi);
                check("flags_cvzn", {flag_c, flag_v, flag_z, flag_n}, e.f);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [1:0] o, input logic [7:0] aa, input logic [7:0] bb,
                        input logic ci, input exp_t e);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        op = o;
        a = aa;
        b = bb;
        carry_in = ci;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready=0 required 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            sb.push_back(e);
            #1;
            in_valid = 1'b0;
            a = 8'($urandom);
            b = 8'($urandom);
            carry_in = ~ci;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && sb.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        exp_t e2;
        int   busy_cnt;
        bit   ready_seen;
        bit   valid_seen;
        int   start_cyc;

        tbl[0]  = '{OPC_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 4'b0101};
        tbl[1]  = '{OPC_SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 8'h00, 4'b0001};
        tbl[2]  = '{OPC_CMP, 8'h05, 8'h05, 1'b0, 8'hFF, 8'h00, 4'b1010};
        tbl[3]  = '{OPC_MUL, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 4'b1001};
        tbl[4]  = '{OPC_ADD, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 4'b1010};
        tbl[5]  = '{OPC_SUB, 8'h80, 8'h01, 1'b1, 8'h7F, 8'h00, 4'b1100};
        tbl[6]  = '{OPC_MUL, 8'h00, 8'h37, 1'b0, 8'h00, 8'h00, 4'b0010};
        tbl[7]  = '{OPC_MUL, 8'h0F, 8'h11, 1'b0, 8'hFF, 8'h00, 4'b0000};
        tbl[8]  = '{OPC_CMP, 8'h03, 8'h05, 1'b0, 8'hFF, 8'h00, 4'b0001};
        tbl[9]  = '{OPC_ADD, 8'h40, 8'h40, 1'b1, 8'h81, 8'h00, 4'b0101};
        tbl[10] = '{OPC_MUL, 8'h80, 8'h02, 1'b0, 8'h00, 8'h01, 4'b1000};
        tbl[11] = '{OPC_CMP, 8'h80, 8'h7F, 1'b1, 8'h00, 8'h01, 4'b1100};
        tbl[12] = '{OPC_SUB, 8'h7F, 8'hFF, 1'b0, 8'h80, 8'h00, 4'b0101};

        // Reset state
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_result_hi", result_hi, 0);
        check("rst_flags", {flag_c, flag_v, flag_z, flag_n}, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table
        for (int i = 0; i < 13; i++) begin
            e.res = tbl[i].res;
            e.hi  = tbl[i].hi;
            e.f   = tbl[i].f;
            send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, e);
        end
        drain();

        // ADD latency: valid in the cycle right after acceptance
        send(OPC_ADD, 8'h7F, 8'h01, 1'b0, '{8'h80, 8'h00, 4'b0101});
        check("add_latency_valid", out_valid, 1);
        drain();

        // MUL timing: busy for 8 cycles, no ready, result in cycle 9
        send(OPC_MUL, 8'hFF, 8'hFF, 1'b0, '{8'h01, 8'hFE, 4'b1001});
        busy_cnt = 0;
        ready_seen = 1'b0;
        valid_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (busy) busy_cnt++;
            if (in_ready) ready_seen = 1'b1;
            if (out_valid) valid_seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("mul_busy_cycles", busy_cnt, 8);
        check("mul_in_ready_low", ready_seen, 0);
        check("mul_early_valid", valid_seen, 0);
        check("mul_valid_at_9", out_valid, 1);
        check("mul_busy_clear", busy, 0);
        drain();

        // Backpressure for 3 cycles with a new request waiting
        out_ready = 1'b0;
        send(OPC_ADD, 8'h12, 8'h34, 1'b1, '{8'h47, 8'h00, 4'b0000});
        in_valid = 1'b1;
        op = OPC_SUB;
        a = 8'h10;
        b = 8'h20;
        carry_in = 1'b1;
        e2 = '{8'hF0, 8'h00, 4'b0001};
        for (int i = 0; i < 3; i++) begin
            check("bp_valid_held", out_valid, 1);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_result_stable", result, 8'h47);
            check("bp_flags_stable", {flag_c, flag_v, flag_z, flag_n}, 4'b0000);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        sb.push_back(e2);
        #1;
        in_valid = 1'b0;
        check("bp_next_valid", out_valid, 1);
        check("bp_next_result", result, 8'hF0);
        drain();

        // Reset during multiply iteration 4
        send(OPC_MUL, 8'h0F, 8'h0F, 1'b0, '{8'hE1, 8'h00, 4'b0000});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        check("abort_result_hi", result_hi, 0);
        check("abort_flags", {flag_c, flag_v, flag_z, flag_n}, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_in_ready", in_ready, 1);
        valid_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid || busy) valid_seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("abort_no_result", valid_seen, 0);

        // Back-to-back random ADDs
        out_ready = 1'b1;
        start_cyc = cyc;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] ra, rb;
            logic       rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom_range(0, 1));
            send(OPC_ADD, ra, rb, rc, model_add(ra, rb, rc));
        end
        check("b2b_cycles", cyc - start_cyc, 16);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
